// File: rtl/screen_scanout.sv
// Video scanout: 640x480 raster timing with the 512x256 screen window centred in it.
// Screen words are fetched through a synchronous read port and shifted out LSB-first as pixels.
module screen_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int X_OFF     = 64,
  parameter int Y_OFF     = 112,
  parameter int INVERT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  output logic [12:0] vram_addr,
  output logic        vram_rd,
  input  logic [15:0] vram_data,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        r,
  output logic        g,
  output logic        b
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] X_LO    = 10'(X_OFF);
  localparam logic [9:0] X_HI    = 10'(X_OFF + 512);
  localparam logic [9:0] Y_LO    = 10'(Y_OFF);
  localparam logic [9:0] FETCH_0 = 10'(X_OFF - 2);
  localparam logic [9:0] LOAD_0  = 10'(X_OFF - 1);
  localparam logic       INV     = (INVERT != 0);

  // Read port: vram_rd is a one-clk strobe qualified by ce; vram_addr stays put between
  // strobes, so vram_data (valid one clk later) remains valid for as long as ce is low.

  logic [12:0] addr_q;
  logic [15:0] shreg;
  logic [9:0]  wy;
  logic [9:0]  fx;
  logic [9:0]  lx;
  logic        in_win_x;
  logic        in_win_y;
  logic        fetch_hit;
  logic        load_hit;
  logic [12:0] fetch_addr;
  logic        hs_n;
  logic        vs_n;
  logic        pix;

  always_comb begin
    wy         = vpos - Y_LO;
    fx         = hpos - FETCH_0;
    lx         = hpos - LOAD_0;
    in_win_x   = (hpos >= X_LO) && (hpos < X_HI);
    in_win_y   = (vpos >= Y_LO) && (wy < 10'd256);
    fetch_hit  = in_win_y && (hpos >= FETCH_0) && (fx < 10'd512) && (fx[3:0] == 4'd0);
    load_hit   = in_win_y && (hpos >= LOAD_0) && (lx < 10'd512) && (lx[3:0] == 4'd0);
    fetch_addr = {wy[7:0], fx[8:4]};
    hs_n       = !((hpos >= HS_LO) && (hpos <= HS_HI));
    vs_n       = !((vpos >= VS_LO) && (vpos <= VS_HI));
    pix        = 1'b0;
    if ((hpos < H_VIS) && (vpos < V_VIS)) begin
      pix = (in_win_x && in_win_y) ? (shreg[0] ^ INV) : INV;
    end
  end

  assign vram_rd   = ce && !reset && fetch_hit;
  assign vram_addr = fetch_hit ? fetch_addr : addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos   <= '0;
      vpos   <= '0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      hblank <= 1'b0;
      vblank <= 1'b0;
      r      <= 1'b0;
      g      <= 1'b0;
      b      <= 1'b0;
      shreg  <= '0;
      addr_q <= '0;
    end else if (ce) begin
      if (hpos == H_LAST) begin
        hpos <= '0;
        vpos <= (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
      end else begin
        hpos <= hpos + 10'd1;
      end
      // Registered decode describes the counters as they were before this edge.
      hsync  <= hs_n;
      vsync  <= vs_n;
      hblank <= (hpos >= H_VIS);
      vblank <= (vpos >= V_VIS);
      r      <= pix;
      g      <= pix;
      b      <= pix;
      // The load edge is also the last shift edge of the previous word; its bit 15 has
      // already reached shreg[0] and is consumed by pix above.
      shreg  <= load_hit ? vram_data : {1'b0, shreg[15:1]};
      if (fetch_hit) begin
        addr_q <= fetch_addr;
      end
    end
  end

endmodule

// File: tb/tb_screen_scanout.sv
// Directed bench for screen_scanout: raster timing, fetch pattern, pixel order,
// ce division and mid-frame reset, checked against a small screen-image model.
module tb_screen_scanout;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [12:0] vram_addr;
  logic        vram_rd;
  logic [15:0] vram_data = '0;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        hsync;
  logic        vsync;
  logic        hblank;
  logic        vblank;
  logic        r;
  logic        g;
  logic        b;

  logic [15:0] mem [0:8191];
  int errors = 0;
  int checks = 0;

  screen_scanout dut (
    .clk(clk), .reset(reset), .ce(ce),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_data(vram_data),
    .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  // Synchronous-read screen memory.
  always @(posedge clk) vram_data <= mem[vram_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Expected {r,g,b} for raster position (x,y) with INVERT=1.
  function automatic logic [2:0] exp_pix(input int x, input int y);
    logic [15:0] w;
    if (x >= 640 || y >= 480) return 3'b000;
    if (x < 64 || x >= 576 || y < 112 || y >= 368) return 3'b111;
    w = mem[(y - 112) * 32 + (x - 64) / 16];
    return w[(x - 64) % 16] ? 3'b000 : 3'b111;
  endfunction

  function automatic logic pix_bad();
    int x;
    x = int'(hpos) - 1;
    return ({r, g, b} !== exp_pix(x, int'(vpos))) ||
           (hblank !== (x >= 640)) || (vblank !== (vpos >= 10'd480));
  endfunction

  logic [2:0]  pix;
  assign pix = {r, g, b};

  int cyc, hs_low, vs_low, rd_n, black_n, diffs, held_bad, line_per;
  logic [9:0]  f_h, f_v, s_h, l_h, l_v;
  logic [12:0] f_a, s_a, l_a;
  logic [29:0] prev, cur;
  logic        ce_used;
  logic        wrapped;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[0]    = 16'h0001;
    mem[8191] = 16'h8000;

    // ---------------- reset ----------------
    reset = 1'b1;
    ce    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_hpos", hpos, 0);
    check("rst_vpos", vpos, 0);
    check("rst_syncs", {hsync, vsync}, 2'b11);
    check("rst_blanks", {hblank, vblank}, 2'b00);
    check("rst_rgb", pix, 0);
    check("rst_rd", vram_rd, 0);
    check("rst_addr", vram_addr, 0);
    reset = 1'b0;

    // ---------------- one full frame, ce=1 ----------------
    cyc = 0; wrapped = 1'b0; hs_low = 0; vs_low = 0; rd_n = 0; black_n = 0; diffs = 0;
    while (!wrapped && cyc < 430000) begin
      @(negedge clk);
      cyc++;
      if (hpos == 10'd0 && vpos == 10'd0) wrapped = 1'b1;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (!hblank && !vblank && pix == 3'b000) black_n++;
      if (hpos != 10'd0 && pix_bad()) diffs++;
      if (vram_rd) begin
        rd_n++;
        if (rd_n == 1) begin f_h = hpos; f_v = vpos; f_a = vram_addr; end
        if (rd_n == 2) begin s_h = hpos; s_a = vram_addr; end
        l_h = hpos; l_v = vpos; l_a = vram_addr;
      end
      if (vpos == 10'd0 && hpos == 10'd656) check("hsync_656", hsync, 1);
      if (vpos == 10'd0 && hpos == 10'd657) check("hsync_657", hsync, 0);
      if (vpos == 10'd0 && hpos == 10'd752) check("hsync_752", hsync, 0);
      if (vpos == 10'd0 && hpos == 10'd753) check("hsync_753", hsync, 1);
      if (vpos == 10'd490 && hpos == 10'd0) check("vsync_489_799", vsync, 1);
      if (vpos == 10'd490 && hpos == 10'd1) check("vsync_490_0", vsync, 0);
      if (vpos == 10'd492 && hpos == 10'd0) check("vsync_491_799", vsync, 0);
      if (vpos == 10'd492 && hpos == 10'd1) check("vsync_492_0", vsync, 1);
      if (vpos == 10'd112 && hpos == 10'd65) check("pix_64_112", pix, 3'b000);
      if (vpos == 10'd112 && hpos == 10'd66) check("pix_65_112", pix, 3'b111);
      if (vpos == 10'd112 && hpos == 10'd64) check("pix_63_112", pix, 3'b111);
      if (vpos == 10'd367 && hpos == 10'd576) check("pix_575_367", pix, 3'b000);
      if (vpos == 10'd367 && hpos == 10'd577) check("pix_576_367", pix, 3'b111);
      if (vpos == 10'd367 && hpos == 10'd641) check("pix_640_367", {hblank, pix}, 4'b1000);
    end
    check("frame_period", cyc, 420000);
    check("hsync_low_clks", hs_low, 525 * 96);
    check("vsync_low_clks", vs_low, 2 * 800);
    check("rd_pulses", rd_n, 8192);
    check("first_rd_addr", f_a, 0);
    check("first_rd_pos", {f_v, f_h}, {10'd112, 10'd62});
    check("second_rd", {s_a, s_h}, {13'd1, 10'd78});
    check("last_rd_addr", l_a, 8191);
    check("last_rd_pos", {l_v, l_h}, {10'd367, 10'd558});
    check("black_pixels", black_n, 2);
    check("image_diffs", diffs, 0);

    // ---------------- ce every 2nd clk ----------------
    repeat (5) @(negedge clk);
    reset = 1'b1;
    ce    = 1'b0;
    @(negedge clk);
    check("rst_ce0_hpos", hpos, 0);
    check("rst_ce0_syncs_rgb", {hsync, vsync, pix}, 5'b11000);
    reset = 1'b0;
    cyc = 0; rd_n = 0; diffs = 0; held_bad = 0; line_per = 0;
    prev = {hpos, vpos, hsync, vsync, hblank, vblank, r, g, b, 3'b000};
    while (vpos != 10'd113 && cyc < 185000) begin
      ce_used = ce;
      @(negedge clk);
      cyc++;
      cur = {hpos, vpos, hsync, vsync, hblank, vblank, r, g, b, 3'b000};
      if (!ce_used && cur !== prev) held_bad++;
      prev = cur;
      if (ce_used && hpos != 10'd0 && pix_bad()) diffs++;
      if (line_per == 0 && vpos == 10'd1 && hpos == 10'd0) line_per = cyc;
      ce = ~ce;
      #1;
      if (vram_rd) begin
        rd_n++;
        if (rd_n == 1) begin f_h = hpos; f_v = vpos; f_a = vram_addr; end
      end
    end
    check("ce2_line_period", line_per, 1600);
    check("ce2_held", held_bad, 0);
    check("ce2_image_diffs", diffs, 0);
    check("ce2_rd_pulses", rd_n, 32);
    check("ce2_first_rd", {f_a, f_v, f_h}, {13'd0, 10'd112, 10'd62});

    // ---------------- mid-frame reset ----------------
    ce  = 1'b1;
    cyc = 0;
    while (!(vpos == 10'd200 && hpos == 10'd300) && cyc < 100000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_200_300", {vpos, hpos}, {10'd200, 10'd300});
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_pos", {hpos, vpos}, 0);
    check("mid_rst_syncs", {hsync, vsync}, 2'b11);
    check("mid_rst_rgb", pix, 0);
    check("mid_rst_rd", vram_rd, 0);
    check("mid_rst_addr", vram_addr, 0);
    reset = 1'b0;
    cyc = 0; rd_n = 0; diffs = 0; black_n = 0;
    while (!(vpos == 10'd113 && hpos == 10'd0) && cyc < 100000) begin
      @(negedge clk);
      cyc++;
      if (hpos != 10'd0 && pix_bad()) diffs++;
      if (!hblank && !vblank && pix == 3'b000) black_n++;
      if (vram_rd) begin
        rd_n++;
        if (rd_n == 1) begin f_h = hpos; f_v = vpos; f_a = vram_addr; end
      end
    end
    check("post_rst_clks", cyc, 113 * 800);
    check("post_rst_first_rd", {f_a, f_v, f_h}, {13'd0, 10'd112, 10'd62});
    check("post_rst_rd_pulses", rd_n, 32);
    check("post_rst_image_diffs", diffs, 0);
    check("post_rst_black", black_n, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
